// File: rtl/key_receiver.sv
// Serial keyboard-style frame receiver: synchronizes the key clock/data lines,
// decodes 11-bit frames (start, 8 data LSB first, odd parity, stop) and flags errors.
//
// state  | meaning
// IDLE   | waiting for a falling edge carrying a start bit (0)
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit and issuing exactly one outcome pulse
module key_receiver #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int CNT_W          = 15
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iKeyClock,
  input  logic       iKeyData,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oParityError,
  output logic       oFrameError,
  output logic       oBusy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state, state_next;
  logic             kc_s1, kc_s2, kc_prev;
  logic             kd_s1, kd_s2;
  logic             fall;
  logic             bit_val;
  logic [2:0]       bit_cnt, bit_cnt_next;
  logic [7:0]       shift, shift_next;
  logic             par_bit, par_bit_next;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_next;
  logic             timeout;
  logic [7:0]       data_next;
  logic             valid_next, perr_next, ferr_next;

  // Sync and history flops reset to the idle-high line level so that
  // releasing reset on a quiet bus produces no spurious edge.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      kc_s1   <= 1'b1;
      kc_s2   <= 1'b1;
      kc_prev <= 1'b1;
      kd_s1   <= 1'b1;
      kd_s2   <= 1'b1;
      fall    <= 1'b0;
      bit_val <= 1'b1;
    end else begin
      kc_s1   <= iKeyClock;
      kc_s2   <= kc_s1;
      kc_prev <= kc_s2;
      kd_s1   <= iKeyData;
      kd_s2   <= kd_s1;
      fall    <= kc_prev & ~kc_s2;
      bit_val <= kd_s2;
    end
  end

  assign timeout = (state != IDLE) && (tmo_cnt >= TMO_LIMIT);

  always_comb begin
    tmo_cnt_next = tmo_cnt;
    if (state == IDLE || fall) begin
      tmo_cnt_next = '0;
    end else if (tmo_cnt != CNT_MAX) begin
      tmo_cnt_next = tmo_cnt + 1'b1;
    end
  end

  // Timeout wins over a coincident edge; that edge is dropped.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    par_bit_next = par_bit;
    data_next    = oData;
    valid_next   = 1'b0;
    perr_next    = 1'b0;
    ferr_next    = 1'b0;
    if (timeout) begin
      state_next = IDLE;
      ferr_next  = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!bit_val) begin
            state_next   = DATA;
            bit_cnt_next = 3'd0;
          end
        end
        DATA: begin
          shift_next = {bit_val, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_next = PARITY;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          par_bit_next = bit_val;
          state_next   = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (!bit_val) begin
            ferr_next = 1'b1;
          end else if (^{shift, par_bit}) begin
            data_next  = shift;
            valid_next = 1'b1;
          end else begin
            perr_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift        <= 8'h00;
      par_bit      <= 1'b0;
      tmo_cnt      <= '0;
      oData        <= 8'h00;
      oValid       <= 1'b0;
      oParityError <= 1'b0;
      oFrameError  <= 1'b0;
    end else begin
      state        <= state_next;
      bit_cnt      <= bit_cnt_next;
      shift        <= shift_next;
      par_bit      <= par_bit_next;
      tmo_cnt      <= tmo_cnt_next;
      oData        <= data_next;
      oValid       <= valid_next;
      oParityError <= perr_next;
      oFrameError  <= ferr_next;
    end
  end

  assign oBusy = (state != IDLE);

endmodule

// File: tb/tb_key_receiver.sv
// Directed bench for key_receiver: good/parity/frame/timeout frames, noise,
// mid-frame reset and stop-bit latency, with timing scaled down from the defaults.
module tb_key_receiver;

  localparam int TMO = 200;
  localparam int BIT = 80;

  logic       clk = 1'b0;
  logic       rst;
  logic       kc;
  logic       kd;
  logic [7:0] data;
  logic       valid, perr, ferr, busy;

  int tests = 0;
  int fails = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_multi = 0, n_busy = 0;
  int bv, bp, bf, bb;

  key_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
    .iClock      (clk),
    .iReset      (rst),
    .iKeyClock   (kc),
    .iKeyData    (kd),
    .oData       (data),
    .oValid      (valid),
    .oParityError(perr),
    .oFrameError (ferr),
    .oBusy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) n_valid++;
    if (perr === 1'b1) n_perr++;
    if (ferr === 1'b1) n_ferr++;
    if ((int'(valid) + int'(perr) + int'(ferr)) > 1) n_multi++;
    if (busy === 1'b1) n_busy++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    bv = n_valid;
    bp = n_perr;
    bf = n_ferr;
    bb = n_busy;
  endtask

  task automatic check_pulses(input string tag, input int ev, input int ep, input int ef);
    check({tag, "_valid"}, 32'(n_valid - bv), 32'(ev));
    check({tag, "_perr"},  32'(n_perr - bp),  32'(ep));
    check({tag, "_ferr"},  32'(n_ferr - bf),  32'(ef));
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    kd = b;
    repeat (BIT / 2) @(negedge clk);
    kc = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    kc = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(s);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [7:0] byte_v;
    rst = 1'b1;
    kc  = 1'b1;
    kd  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_data",  32'(data),  32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_perr",  32'(perr),  32'h0);
    check("rst_ferr",  32'(ferr),  32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Good 0x1C frame with explicit stop-bit latency probe
    mark();
    byte_v = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(byte_v[i]);
    send_bit(1'b0);
    @(negedge clk);
    kd = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    kc = 1'b0;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 check("lat_n2", 32'(valid), 32'h0);
    @(posedge clk);
    #1 check("lat_n3", 32'(valid), 32'h1);
    @(posedge clk);
    #1 check("lat_n4", 32'(valid), 32'h0);
    repeat (BIT / 2) @(negedge clk);
    kc = 1'b1;
    repeat (10) @(negedge clk);
    check_pulses("good1c", 1, 0, 0);
    check("good1c_data", 32'(data), 32'h1C);
    check("good1c_busy", 32'(busy), 32'h0);

    // Bad parity
    mark();
    send_frame(8'h1C, 1'b1, 1'b1);
    check_pulses("par", 0, 1, 0);
    check("par_data", 32'(data), 32'h1C);

    // Bad stop bit
    mark();
    send_frame(8'hF0, 1'b1, 1'b0);
    check_pulses("stop", 0, 0, 1);
    check("stop_data", 32'(data), 32'h1C);

    // Timeout after start + 4 data bits
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    check("tmo_busy_mid", 32'(busy), 32'h1);
    for (int i = 0; i < TMO + 100 && n_ferr == bf; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_pulses("tmo", 0, 0, 1);
    check("tmo_busy", 32'(busy), 32'h0);
    check("tmo_data", 32'(data), 32'h1C);
    mark();
    send_frame(8'hF0, 1'b1, 1'b1);
    check_pulses("post_tmo", 1, 0, 0);
    check("post_tmo_data", 32'(data), 32'hF0);

    // Noise edge carrying a 1 in IDLE
    mark();
    send_bit(1'b1);
    repeat (10) @(negedge clk);
    check("noise_busy_cycles", 32'(n_busy - bb), 32'h0);
    check_pulses("noise", 0, 0, 0);

    // Reset in the middle of a frame
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_pulses("midrst", 0, 0, 0);
    mark();
    send_frame(8'h5A, 1'b1, 1'b1);
    check_pulses("good5a", 1, 0, 0);
    check("good5a_data", 32'(data), 32'h5A);

    check("one_hot_outcomes", 32'(n_multi), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
